w_pattern_gen: RTL and testbench

Serial stimulus transmitter for the `w`/`z` sequence-detector interface. It accepts a parallel bit pattern through a valid/ready load port and shifts it out LSB-first on `w`, one bit per clock. It sits upstream of the sequence detector, driving its `w` input. An optional compiled-in golden model predicts the detector's `z` and counts mismatches against the returned `z`.

---
 rtl/w_pattern_pkg.sv | 8 +
 rtl/w_seq_model.sv | 19 +
 rtl/w_pattern_gen.sv | 70 +++++++
 tb/tb_w_pattern_gen.sv | 125 ++++++++++++
 4 files changed

// File: rtl/w_pattern_pkg.sv
// w_pattern_pkg: shared FSM/model state types and the length clamp for w_pattern_gen
package w_pattern_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} gen_state_t;
  typedef enum logic [1:0] {A = 2'b00, B = 2'b01, C = 2'b10} model_state_t;
  function automatic int eff_len(input int len, input int width);
    return (len == 0 || len > width) ? width : len;
  endfunction
endpackage

// File: rtl/w_seq_model.sv
// w_seq_model: golden detector, exp_z high after two or more consecutive 1s on w
// Ports: clk, rst (async, active-high), w (serial bit), exp_z (predicted detector output)
module w_seq_model
  import w_pattern_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic w,
  output logic exp_z
);
  model_state_t s, s_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= A;
    else s <= s_n;
  always_comb begin
    s_n = w ? ((s == A) ? B : C) : A;
  end
  assign exp_z = (s == C);
endmodule

// File: rtl/w_pattern_gen.sv
// w_pattern_gen: loads a parallel pattern over valid/ready and shifts it out LSB-first on w
// Ports: clk, rst (async, active-high); load_valid/load_ready/load_data/load_len load port;
//   w, w_valid serial output; busy, done status; z_in detector return; mismatch, err_cnt check results.
// Build option W_PATTERN_GEN_Z_CHECK_EN adds a golden detector model that checks z_in;
//   without it z_in is ignored and mismatch/err_cnt are tied to 0.
module w_pattern_gen
  import w_pattern_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  input  logic             z_in,
  output logic             mismatch,
  output logic [7:0]       err_cnt
);
  gen_state_t state, state_n;
  logic [WIDTH-1:0] sr;
  logic [LEN_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && load_valid) begin
        sr <= load_data;
        cnt <= LEN_W'(eff_len(int'(load_len), WIDTH));
      end else if (state == SHIFT) begin
        sr <= sr >> 1;
        cnt <= cnt - LEN_W'(1);
      end
    end
  always_comb begin
    state_n = (state == IDLE)  ? (load_valid ? SHIFT : IDLE) :
              (state == SHIFT) ? ((cnt == LEN_W'(1)) ? DONE : SHIFT) : IDLE;
  end
  assign load_ready = (state == IDLE);
  assign w_valid    = (state == SHIFT);
  assign w          = w_valid & sr[0];
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
`ifdef W_PATTERN_GEN_Z_CHECK_EN
  logic exp_z;
  w_seq_model u_model (.clk(clk), .rst(rst), .w(w), .exp_z(exp_z));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mismatch <= 1'b0;
      err_cnt <= '0;
    end else begin
      mismatch <= exp_z ^ z_in;
      err_cnt <= ((exp_z ^ z_in) && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end
`else
  logic unused_z;
  assign unused_z = z_in;
  assign mismatch = 1'b0;
  assign err_cnt  = '0;
`endif
endmodule

// File: tb/tb_w_pattern_gen.sv
// tb_w_pattern_gen: directed self-checking bench for w_pattern_gen
module tb_w_pattern_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_data = '0;
  logic [3:0] load_len = '0;
  logic       w, w_valid, busy, done;
  logic       z_in = 1'b0;
  logic       mismatch;
  logic [7:0] err_cnt;
  int checks = 0;
  int failures = 0;

  w_pattern_gen dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .w(w), .w_valid(w_valid),
    .busy(busy), .done(done), .z_in(z_in), .mismatch(mismatch), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] data, input logic [3:0] len, input int n);
    chk("ready_before", load_ready, 1);
    load_data = data;
    load_len = len;
    load_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("bit%0d", i), {w_valid, busy, w}, {2'b11, data[i]});
      @(negedge clk);
    end
    chk("done_cycle", {done, w, w_valid, load_ready, busy}, 5'b10001);
    @(negedge clk);
    chk("after_done", {done, load_ready, busy, w_valid}, 4'b0100);
  endtask

  initial begin
    #3 rst = 1'b1;
    #1 chk("rst_async", {w, w_valid, load_ready, busy, done, mismatch}, 6'b001000);
    chk("rst_err", err_cnt, 0);
    @(posedge clk);
    @(posedge clk);
    #1 chk("rst_hold", {w, w_valid, load_ready, busy, done}, 5'b00100);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'b0000_0110, 4'd4, 4);
    send(8'hFF, 4'd0, 8);
    send(8'hA5, 4'd9, 8);
    send(8'h01, 4'd1, 1);
    // continuous load_valid: two back-to-back patterns with a 2-cycle gap
    load_data = 8'b101;
    load_len = 4'd3;
    load_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_data = 8'b0110;
    load_len = 4'd4;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_a%0d", i), {w_valid, w}, {1'b1, i[0] ? 1'b0 : 1'b1});
      @(negedge clk);
    end
    chk("b2b_done", {done, w, w_valid}, 3'b100);
    @(negedge clk);
    chk("b2b_idle", {load_ready, w, w_valid}, 3'b100);
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_b%0d", i), {w_valid, w}, {1'b1, (i == 1 || i == 2) ? 1'b1 : 1'b0});
      @(negedge clk);
    end
    chk("b2b_done2", done, 1);
    @(negedge clk);
    // reset during bit 3 of an 8-bit pattern
    load_data = 8'hFF;
    load_len = 4'd8;
    load_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_bit3", {w_valid, w}, 2'b11);
    #2 rst = 1'b1;
    #1 chk("mid_rst", {w, w_valid, busy, load_ready}, 4'b0001);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_after", {load_ready, busy, w_valid}, 3'b100);
    @(negedge clk);
    chk("mid_noresume", {load_ready, w_valid, w}, 3'b100);
`ifdef W_PATTERN_GEN_Z_CHECK_EN
    z_in = 1'b0;
    load_data = 8'b111;
    load_len = 4'd3;
    load_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("zchk_mm%0d", i), mismatch, (i == 4 || i == 5) ? 1 : 0);
      @(negedge clk);
    end
    chk("zchk_err", err_cnt, 2);
`else
    z_in = 1'b1;
    send(8'h0F, 4'd4, 4);
    chk("nochk_mm", mismatch, 0);
    chk("nochk_err", err_cnt, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
